// File: rtl/dsa_step_controller.sv
// dsa_step_controller: debug run-control FSM that stalls/steps the DSA, halts on breakpoints and serves register reads.
module dsa_step_controller #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [15:0]       cmd_arg,
  input  logic [31:0]       debug_reg_0,
  input  logic [31:0]       debug_reg_1,
  input  logic [31:0]       debug_reg_2,
  input  logic [31:0]       debug_reg_3,
  input  logic [31:0]       debug_reg_4,
  input  logic [31:0]       debug_reg_5,
  input  logic [31:0]       debug_reg_6,
  input  logic [31:0]       debug_reg_7,
  output logic              dsa_stall,
  output logic              capture_enable,
  output logic              step_ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              halted,
  output logic              break_hit,
  output logic [STEP_W-1:0] steps_remaining
);
  localparam logic [2:0] OP_RUN = 3'd1, OP_HALT = 3'd2, OP_STEP = 3'd3, OP_READ = 3'd4,
                         OP_BRK_SET = 3'd5, OP_BRK_CLR = 3'd6;
  typedef enum logic [1:0] {S_HALTED, S_RUN, S_ADV, S_CAP} state_t;
  state_t r_state, w_next;
  logic              r_break_en;
  logic [3:0]        r_break_state;
  logic              r_break_hit;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic [STEP_W-1:0] r_steps;
  logic              w_acc, w_brk;
  logic [STEP_W-1:0] w_cnt;
  logic [31:0]       w_regs [8];
  assign w_regs = '{debug_reg_0, debug_reg_1, debug_reg_2, debug_reg_3,
                    debug_reg_4, debug_reg_5, debug_reg_6, debug_reg_7};
  assign cmd_ready = (r_state == S_HALTED || r_state == S_RUN) && !r_rsp_valid;
  assign w_acc = cmd_valid && cmd_ready;
  assign w_brk = r_state == S_RUN && r_break_en && debug_reg_0[27:24] == r_break_state;
  assign w_cnt = STEP_W'(cmd_arg);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HALTED: w_next = (w_acc && cmd_op == OP_RUN)  ? S_RUN :
                         (w_acc && cmd_op == OP_STEP) ? S_ADV : S_HALTED;
      S_RUN:    w_next = (w_brk || (w_acc && cmd_op == OP_HALT)) ? S_HALTED : S_RUN;
      S_ADV:    w_next = S_CAP;
      S_CAP:    w_next = (r_steps <= STEP_W'(1)) ? S_HALTED : S_ADV;
      default:  w_next = S_HALTED;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HALTED;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_break_en    <= 1'b0;
      r_break_state <= '0;
      r_break_hit   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_steps       <= '0;
    end else begin
      if (w_acc && cmd_op == OP_BRK_SET) begin
        r_break_en    <= 1'b1;
        r_break_state <= cmd_arg[3:0];
      end else if (w_acc && cmd_op == OP_BRK_CLR) begin
        r_break_en <= 1'b0;
      end
      if (w_brk) r_break_hit <= 1'b1;
      else if (r_state == S_HALTED && w_acc && cmd_op == OP_RUN) r_break_hit <= 1'b0;
      if (w_acc && cmd_op == OP_READ) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_regs[cmd_arg[2:0]];
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      // count 0 is promoted to a single step
      if (r_state == S_HALTED && w_acc && cmd_op == OP_STEP) r_steps <= (w_cnt == '0) ? STEP_W'(1) : w_cnt;
      else if (r_state == S_CAP) r_steps <= r_steps - STEP_W'(1);
    end
  end
  assign dsa_stall       = r_state == S_HALTED || r_state == S_CAP;
  assign capture_enable  = r_state != S_RUN;
  assign step_ack        = r_state == S_CAP;
  assign halted          = r_state == S_HALTED;
  assign break_hit       = r_break_hit;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign steps_remaining = r_steps;
endmodule

// File: tb/tb_dsa_step_controller.sv
// tb_dsa_step_controller: directed-vector bench for dsa_step_controller with hand-computed expectations.
module tb_dsa_step_controller;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [15:0] cmd_arg = '0;
  logic [31:0] dr0 = '0, dr1 = 32'h1111_1111, dr2 = '0, dr3 = '0, dr4 = '0, dr5 = '0, dr6 = '0, dr7 = '0;
  logic        dsa_stall, capture_enable, step_ack, rsp_valid, halted, break_hit;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [15:0] steps_remaining;
  int          n_vec = 0, n_err = 0, acks;
  dsa_step_controller #(.STEP_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .debug_reg_0(dr0), .debug_reg_1(dr1), .debug_reg_2(dr2), .debug_reg_3(dr3),
    .debug_reg_4(dr4), .debug_reg_5(dr5), .debug_reg_6(dr6), .debug_reg_7(dr7),
    .dsa_stall(dsa_stall), .capture_enable(capture_enable), .step_ack(step_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .halted(halted), .break_hit(break_hit), .steps_remaining(steps_remaining)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] op, input logic [15:0] arg);
    chk("cmd_ready_before_send", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cyc();
    cmd_valid = 1'b0;
  endtask
  task automatic chk_ctl(input string tag, input logic h, input logic st, input logic ce, input logic ack);
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, h});
    chk({tag, "_stall"}, {31'd0, dsa_stall}, {31'd0, st});
    chk({tag, "_cap_en"}, {31'd0, capture_enable}, {31'd0, ce});
    chk({tag, "_ack"}, {31'd0, step_ack}, {31'd0, ack});
  endtask
  initial begin
    cyc(); cyc();
    chk_ctl("reset", 1, 1, 1, 0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_break_hit", {31'd0, break_hit}, 0);
    chk("reset_steps", {16'd0, steps_remaining}, 0);
    rst = 1'b0;
    cyc();
    // READ with response held under back-pressure
    dr2 = 32'hAABB_CCDD;
    send(3'd4, 16'd2);
    chk("read_valid", {31'd0, rsp_valid}, 1);
    chk("read_data", rsp_data, 32'hAABB_CCDD);
    dr2 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("read_hold_valid", {31'd0, rsp_valid}, 1);
      chk("read_hold_data", rsp_data, 32'hAABB_CCDD);
      chk("read_hold_cmd_ready", {31'd0, cmd_ready}, 0);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("read_done_valid", {31'd0, rsp_valid}, 0);
    chk("read_done_cmd_ready", {31'd0, cmd_ready}, 1);
    // STEP 3: ADV/CAP alternate, steps 3,3,2,2,1,1 then HALTED with 0
    send(3'd3, 16'd3);
    acks = 0;
    for (int k = 1; k <= 6; k++) begin
      chk_ctl("step3", 0, (k % 2) == 0, 1, (k % 2) == 0);
      chk("step3_steps", {16'd0, steps_remaining}, 32'(3 - (k - 1) / 2));
      chk("step3_cmd_ready", {31'd0, cmd_ready}, 0);
      acks += int'(step_ack);
      cyc();
    end
    chk_ctl("step3_end", 1, 1, 1, 0);
    chk("step3_end_steps", {16'd0, steps_remaining}, 0);
    chk("step3_acks", 32'(acks), 3);
    // STEP 0 behaves as one step
    send(3'd3, 16'd0);
    chk_ctl("step0_adv", 0, 0, 1, 0);
    chk("step0_steps", {16'd0, steps_remaining}, 1);
    cyc();
    chk_ctl("step0_cap", 0, 1, 1, 1);
    cyc();
    chk_ctl("step0_end", 1, 1, 1, 0);
    // breakpoint on FSM state 5
    send(3'd5, 16'd5);
    send(3'd1, 16'd0);
    chk_ctl("run", 0, 0, 0, 0);
    cyc();
    chk_ctl("run_nobrk", 0, 0, 0, 0);
    dr0 = 32'h0500_0000;
    cyc();
    chk_ctl("brk", 1, 1, 1, 0);
    chk("brk_hit", {31'd0, break_hit}, 1);
    dr0 = 32'h0;
    send(3'd1, 16'd0);
    chk("run_clears_hit", {31'd0, break_hit}, 0);
    chk_ctl("rerun", 0, 0, 0, 0);
    // STEP ignored in RUN; READ served in RUN
    send(3'd3, 16'd4);
    chk_ctl("step_in_run", 0, 0, 0, 0);
    chk("step_in_run_steps", {16'd0, steps_remaining}, 0);
    dr7 = 32'h1234_5678;
    send(3'd4, 16'd7);
    chk("read_run_data", rsp_data, 32'h1234_5678);
    chk_ctl("read_run", 0, 0, 0, 0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    // HALT and breakpoint in the same cycle
    dr0 = 32'h0500_0000;
    send(3'd2, 16'd0);
    chk_ctl("halt_brk", 1, 1, 1, 0);
    chk("halt_brk_hit", {31'd0, break_hit}, 1);
    // disabled breakpoint does not fire; plain HALT leaves break_hit clear
    send(3'd6, 16'd0);
    send(3'd1, 16'd0);
    cyc();
    chk_ctl("brk_clr_run", 0, 0, 0, 0);
    send(3'd2, 16'd0);
    chk_ctl("halt", 1, 1, 1, 0);
    chk("halt_hit", {31'd0, break_hit}, 0);
    dr0 = 32'h0;
    // asynchronous reset during STEP_ADV discards pending steps
    send(3'd3, 16'd5);
    chk_ctl("rst_step_adv", 0, 0, 1, 0);
    chk("rst_step_steps", {16'd0, steps_remaining}, 5);
    rst = 1'b1;
    #2;
    chk_ctl("rst_async", 1, 1, 1, 0);
    chk("rst_async_steps", {16'd0, steps_remaining}, 0);
    cyc();
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      acks += int'(step_ack);
    end
    chk("rst_no_acks", 32'(acks), 0);
    chk_ctl("rst_after", 1, 1, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
